clk_gen_ctrl: RTL and testbench
===============================

Name: clk_gen_ctrl

Overview:
- Programmable clock-generator controller for the tiny-tapeout top level.
- Top level maps `ui_in`/`uio_in` onto the config interface and drives `clk_out` onto `uo_out[0]`.
- Accepts divider/mode/burst configuration over a valid/ready handshake and produces a divided clock, either continuously or as a counted burst.
- New configuration is applied only at clock-period boundaries, so `clk_out` never carries a runt pulse.

Parameters:
- DIV_W, 8, width of half-period divider value.
- BURST_W, 8, width of burst pulse count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; high when no config is pending.
- cfg_mode  in  2  00 stop, 01 continuous, 10 burst, 11 reserved (treated as stop).
- cfg_div  in  DIV_W  half-period minus one.
- cfg_burst  in  BURST_W  number of `clk_out` periods in burst mode.
- clk_out  out  1  generated clock, registered.
- period_tick  out  1  one-cycle pulse in the cycle `clk_out` rises.
- busy  out  1  high in RUN or BURST.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- **Reset.** Asynchronous, active-low. `clk_out`, `period_tick`, `busy`, `done` = 0; `cfg_ready` = 1; state IDLE; pending flag, counters and active config = 0. Assertion mid-operation forces `clk_out` low immediately; no completion pulse.
- **Divider.**
  - Half-period down-counter loads `div_active`. At 0 it toggles `clk_out` and reloads.
  - f_out = f_clk / (2*(div+1)). div=0 gives clk/2; div=255 gives clk/512.
  - Counter arithmetic is unsigned and never wraps below 0.
- **Period boundary.** The cycle in which the counter is 0 and `clk_out` is 1 (falling toggle).
- **Handshake.**
  - Transfer when `cfg_valid && cfg_ready`. Fields are captured into a pending register and the pending flag is set.
  - `cfg_ready` = !pending (registered flag). While pending, `cfg_valid` is ignored and must be held by the source.
  - Pending clears in the cycle its config is applied.
- **States.**
  - IDLE:
    - `clk_out`=0.
    - Pending with mode 01: load `div_active`, go to RUN next cycle; first rising toggle occurs div+1 cycles after entry.
    - Pending with mode 10 and burst>0: go to BURST with `remaining` = burst.
    - Pending with mode 00/11, or burst==0: consume and stay IDLE (no `done`).
  - RUN: at a period boundary with pending, apply as from IDLE, except that stop returns to IDLE with `clk_out` already low. Without pending, keep running.
  - BURST:
    - Each period boundary decrements `remaining`.
    - When it reaches 0: pulse `done` in the same cycle as the falling toggle.
    - Then apply pending if present (same transition rules); otherwise go to IDLE.
    - Pending config is never applied before the burst completes.
- **Simultaneous events.**
  - A transfer accepted in the same cycle as a boundary is not applied at that boundary; it waits for the next one (IDLE: the next cycle).
  - `done` and a new BURST entry may occur on the same cycle.
- **Timing.** `period_tick` asserts in the same cycle the `clk_out` register becomes 1; it is registered alongside `clk_out`.

Optional Feature:
- Macro: CLK_GEN_PAUSE_EN.
- Defined: adds input `pause` (1 bit). While `pause`=1 in RUN or BURST, the half-period counter and `remaining` freeze, `clk_out` holds its level, no `period_tick` or boundary occurs, and pending config is not applied. Handshake acceptance continues. Releasing `pause` resumes counting from the frozen value.
- Undefined: no `pause` port; the counter always advances.

Decomposition:
- Package `clk_gen_pkg`:
  - mode constants MODE_STOP=2'b00, MODE_RUN=2'b01, MODE_BURST=2'b10.
  - state typedef {IDLE, RUN, BURST}.
  - default DIV_W/BURST_W localparams.
  - cfg struct {mode, div, burst}.
- One sub-module, `clk_gen_halfper_cnt`: loadable down-counter with reload, enable, and terminal-count output. The FSM, handshake and burst counter stay in `clk_gen_ctrl`.

Test Plan:
- Reset then mode=01, div=0 → `clk_out` toggles every cycle (period 2); `period_tick` every 2 cycles; `busy`=1.
- RUN div=3, send div=1 mid-period → `cfg_ready` low until next falling boundary; then period changes from 8 to 4 with no pulse shorter than 2 cycles.
- mode=10, div=2, burst=3 → exactly 3 rising edges (period 6), `done` pulse with the 3rd falling toggle, then IDLE, `busy`=0, `clk_out`=0.
- Burst=4 running, send mode=01 div=0 during it → 4 full periods, then continuous clk/2 starting at the `done` cycle; `done` pulses once.
- mode=10 burst=0, and mode=11 → accepted (`cfg_ready` pulses low 1 cycle), state stays IDLE, no `done`, `clk_out` stays 0.
- Assert `rst_n` low mid-burst (async, between clk edges) → `clk_out`/`busy` drop immediately; after release, `cfg_ready`=1 and no `done`. With CLK_GEN_PAUSE_EN: pause 5 cycles in RUN div=3 → `clk_out` frozen, period stretched by exactly 5.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared types, mode encodings and default widths for the clock-generator controller.
package clk_gen_pkg;

    localparam int unsigned DIV_W_DEF   = 8;
    localparam int unsigned BURST_W_DEF = 8;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

    typedef struct packed {
        logic [1:0]             mode;
        logic [DIV_W_DEF-1:0]   div;
        logic [BURST_W_DEF-1:0] burst;
    } cfg_t;

endpackage

// File: rtl/clk_gen_if.sv
// Config handshake and generated-clock outputs of clk_gen_ctrl.
// Defining CLK_GEN_PAUSE_EN adds the pause input.
interface clk_gen_if
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) ();

    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_mode;
    logic [DIV_W-1:0]   cfg_div;
    logic [BURST_W-1:0] cfg_burst;
    logic               clk_out;
    logic               period_tick;
    logic               busy;
    logic               done;
`ifdef CLK_GEN_PAUSE_EN
    logic               pause;
`endif

    modport master (
        output cfg_valid, cfg_mode, cfg_div, cfg_burst,
`ifdef CLK_GEN_PAUSE_EN
        output pause,
`endif
        input  cfg_ready, clk_out, period_tick, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_div, cfg_burst,
`ifdef CLK_GEN_PAUSE_EN
        input  pause,
`endif
        output cfg_ready, clk_out, period_tick, busy, done
    );

endinterface

// File: rtl/clk_gen_halfper_cnt.sv
// Half-period down-counter: explicit load wins, otherwise reloads at terminal count while enabled.
module clk_gen_halfper_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reload_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = tc ? reload_val : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable clock generator: config over valid/ready, continuous or counted-burst output.
// Defining CLK_GEN_PAUSE_EN adds a pause input that freezes the running generator.
module clk_gen_ctrl
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input logic      clk,
    input logic      rst_n,
    clk_gen_if.slave bus
);

    state_t             state_q, state_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               pend_q, pend_d;
    logic [1:0]         pend_mode_q;
    logic [DIV_W-1:0]   pend_div_q, div_q, div_d;
    logic [BURST_W-1:0] pend_burst_q, rem_q, rem_d;
    logic               active, paused, cnt_en, tc, toggle, boundary, apply, accept;

`ifdef CLK_GEN_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    assign active   = (state_q == RUN) || (state_q == BURST);
    assign cnt_en   = active && !paused;
    assign toggle   = cnt_en && tc;
    // Falling toggle: the only point where new config may take effect.
    assign boundary = toggle && clk_out_q;
    assign accept   = bus.cfg_valid && !pend_q;

    clk_gen_halfper_cnt #(
        .W(DIV_W)
    ) u_halfper_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (cnt_en),
        .load      (apply),
        .load_val  (pend_div_q),
        .reload_val(div_q),
        .tc        (tc)
    );

    always_comb begin
        state_d   = state_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        rem_d     = rem_q;
        div_d     = div_q;
        apply     = 1'b0;

        if (toggle) begin
            clk_out_d = !clk_out_q;
            tick_d    = !clk_out_q;
        end

        unique case (state_q)
            IDLE: begin
                clk_out_d = 1'b0;
                apply     = pend_q;
            end
            RUN: apply = boundary && pend_q;
            BURST: begin
                if (boundary) begin
                    rem_d = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        apply   = pend_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop, reserved mode and zero-length bursts all land in IDLE.
        if (apply) begin
            div_d   = pend_div_q;
            state_d = IDLE;
            if (pend_mode_q == MODE_RUN) begin
                state_d = RUN;
            end else if (pend_mode_q == MODE_BURST && pend_burst_q != '0) begin
                state_d = BURST;
                rem_d   = pend_burst_q;
            end
        end

        pend_d = accept ? 1'b1 : (apply ? 1'b0 : pend_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_mode_q  <= '0;
            pend_div_q   <= '0;
            pend_burst_q <= '0;
            div_q        <= '0;
            rem_q        <= '0;
        end else begin
            state_q   <= state_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            if (accept) begin
                pend_mode_q  <= bus.cfg_mode;
                pend_div_q   <= bus.cfg_div;
                pend_burst_q <= bus.cfg_burst;
            end
        end
    end

    assign bus.cfg_ready   = !pend_q;
    assign bus.clk_out     = clk_out_q;
    assign bus.period_tick = tick_q;
    assign bus.busy        = active;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Bench for clk_gen_ctrl: directed vector table, corner sequences and a randomized run, all
// checked every cycle against a reference model built on segment timing arithmetic.
module tb_clk_gen_ctrl;
    import clk_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_gen_if #(.DIV_W(8), .BURST_W(8)) bus ();

    clk_gen_ctrl #(
        .DIV_W  (8),
        .BURST_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observation counters and reference-model state.
    int cyc = 0, rise_cnt = 0, tick_cnt = 0, done_cnt = 0, last_rise = 0, rise_gap = 0;
    bit prev_clk = 1'b0;
    int m_mode = 0;              // 0 idle, 1 continuous, 2 burst
    int unsigned m_start = 0, m_div = 0, m_burst = 0;
    bit m_pend = 1'b0, m_done_nx = 1'b0, m_tick_ok = 1'b1;
    int p_mode = 0;
    int unsigned p_div = 0, p_burst = 0;

    // The output of an active segment is a pure function of cycles since it started:
    // low for div+1 cycles, high for div+1 cycles, repeated.
    always @(negedge clk) begin
        int unsigned e, p, ph, k;
        bit act, lvl, tk, pz, bnd, last, acc;
        cyc++;
        if (bus.clk_out && !prev_clk) begin
            rise_gap  = cyc - last_rise;
            last_rise = cyc;
            rise_cnt++;
        end
        prev_clk = bus.clk_out;
        if (bus.period_tick) tick_cnt++;
        if (bus.done) done_cnt++;

        if (!rst_n) begin
            check("m_rst_clk_out", int'(bus.clk_out), 0);
            check("m_rst_tick", int'(bus.period_tick), 0);
            check("m_rst_busy", int'(bus.busy), 0);
            check("m_rst_done", int'(bus.done), 0);
            check("m_rst_ready", int'(bus.cfg_ready), 1);
            m_mode = 0; m_pend = 1'b0; m_done_nx = 1'b0; m_tick_ok = 1'b1;
        end else begin
            act = (m_mode != 0);
            e = 0; p = 2; ph = 0; k = 0; lvl = 1'b0; tk = 1'b0;
            if (act) begin
                e   = cyc - m_start;
                p   = 2 * (m_div + 1);
                ph  = e % p;
                k   = e / p;
                lvl = (ph > m_div);
                tk  = (ph == m_div + 1) && m_tick_ok;
            end
            check("m_clk_out", int'(bus.clk_out), int'(lvl));
            check("m_tick", int'(bus.period_tick), int'(tk));
            check("m_busy", int'(bus.busy), int'(act));
            check("m_done", int'(bus.done), int'(m_done_nx));
            check("m_ready", int'(bus.cfg_ready), int'(!m_pend));

            acc = bus.cfg_valid && !m_pend;
            pz  = 1'b0;
`ifdef CLK_GEN_PAUSE_EN
            pz = act && bus.pause;
`endif
            m_done_nx = 1'b0;
            m_tick_ok = !pz;
            if (pz) begin
                m_start++;
            end else begin
                bnd       = act && (ph == p - 1);
                last      = (m_mode == 2) && bnd && (k == m_burst - 1);
                m_done_nx = last;
                if (m_pend && (!act || (m_mode == 1 && bnd) || last)) begin
                    m_pend  = 1'b0;
                    m_start = cyc + 1;
                    m_div   = p_div;
                    m_burst = p_burst;
                    m_mode  = (p_mode == 1) ? 1 : ((p_mode == 2 && p_burst != 0) ? 2 : 0);
                end else if (last) begin
                    m_mode = 0;
                end
            end
            if (acc) begin
                m_pend  = 1'b1;
                p_mode  = int'(bus.cfg_mode);
                p_div   = bus.cfg_div;
                p_burst = bus.cfg_burst;
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(cfg_t c);
        int w = 0;
        while (!bus.cfg_ready && w < 2000) begin
            step();
            w++;
        end
        check("send_ready_timeout", int'(w < 2000), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = c.mode;
        bus.cfg_div   = c.div;
        bus.cfg_burst = c.burst;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int w = 0;
        while ((bus.busy || !bus.cfg_ready) && w < 2000) begin
            step();
            w++;
        end
        check(name, int'(w < 2000), 1);
    endtask

    task automatic wait_rises(int target, string name);
        int w = 0;
        while (rise_cnt < target && w < 200) begin
            step();
            w++;
        end
        check(name, int'(rise_cnt >= target), 1);
    endtask

    typedef struct {
        cfg_t cfg;
        int   cycles;
        int   exp_rises;
        int   exp_dones;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r0, k0, d0, n;
        vecs[0] = '{'{MODE_BURST, 8'd2, 8'd3}, 40, 3, 1};
        vecs[1] = '{'{MODE_BURST, 8'd5, 8'd0}, 20, 0, 0};
        vecs[2] = '{'{2'b11, 8'd4, 8'd7}, 20, 0, 0};
        vecs[3] = '{'{MODE_STOP, 8'd1, 8'd1}, 20, 0, 0};
        vecs[4] = '{'{MODE_BURST, 8'd0, 8'd1}, 10, 1, 1};
        vecs[5] = '{'{MODE_BURST, 8'd255, 8'd1}, 600, 1, 1};
        vecs[6] = '{'{MODE_BURST, 8'd0, 8'd5}, 20, 5, 1};

        bus.cfg_valid = 1'b0;
        bus.cfg_mode  = '0;
        bus.cfg_div   = '0;
        bus.cfg_burst = '0;
`ifdef CLK_GEN_PAUSE_EN
        bus.pause = 1'b0;
`endif
        step(3);
        check("reset_ready", int'(bus.cfg_ready), 1);
        check("reset_clk_out", int'(bus.clk_out), 0);
        rst_n = 1'b1;
        step(2);

        // Continuous clk/2.
        send('{MODE_RUN, 8'd0, 8'd0});
        step(4);
        check("run_div0_busy", int'(bus.busy), 1);
        r0 = rise_cnt; k0 = tick_cnt;
        step(20);
        check("run_div0_rises", rise_cnt - r0, 10);
        check("run_div0_ticks", tick_cnt - k0, 10);
        check("run_div0_gap", rise_gap, 2);
        send('{MODE_STOP, 8'd0, 8'd0});
        wait_idle("run_div0_stop_timeout");

        // Reconfigure div 3 -> 1 while in the high half of a period.
        send('{MODE_RUN, 8'd3, 8'd0});
        step(6);
        send('{MODE_RUN, 8'd1, 8'd0});
        n = 0;
        while (!bus.cfg_ready && n < 100) begin
            step();
            n++;
        end
        check("reconf_ready_low", n, 2);
        r0 = rise_cnt;
        wait_rises(r0 + 2, "reconf_rise_timeout");
        check("reconf_new_gap", rise_gap, 4);
        send('{MODE_STOP, 8'd0, 8'd0});
        wait_idle("reconf_stop_timeout");

        // Table of single configurations started from IDLE.
        for (int i = 0; i < 7; i++) begin
            r0 = rise_cnt; d0 = done_cnt;
            send(vecs[i].cfg);
            n = 0;
            while (!bus.cfg_ready && n < 100) begin
                step();
                n++;
            end
            check("vec_ready_low", n, 1);
            step(vecs[i].cycles);
            check("vec_rises", rise_cnt - r0, vecs[i].exp_rises);
            check("vec_dones", done_cnt - d0, vecs[i].exp_dones);
            check("vec_busy_end", int'(bus.busy), 0);
            check("vec_clk_end", int'(bus.clk_out), 0);
        end

        // Burst with a continuous config queued behind it.
        r0 = rise_cnt; d0 = done_cnt;
        send('{MODE_BURST, 8'd1, 8'd4});
        send('{MODE_RUN, 8'd0, 8'd0});
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            step();
            n++;
        end
        check("chain_done_seen", int'(done_cnt != d0), 1);
        check("chain_burst_rises", rise_cnt - r0, 4);
        check("chain_busy_after", int'(bus.busy), 1);
        r0 = rise_cnt;
        step(20);
        check("chain_run_rises", rise_cnt - r0, 10);
        check("chain_done_once", done_cnt - d0, 1);
        send('{MODE_STOP, 8'd0, 8'd0});
        wait_idle("chain_stop_timeout");

        // Asynchronous reset in the high half of a burst period.
        send('{MODE_BURST, 8'd3, 8'd10});
        n = 0;
        while (!bus.clk_out && n < 100) begin
            step();
            n++;
        end
        check("arst_high_seen", int'(bus.clk_out), 1);
        d0 = done_cnt;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_clk_out", int'(bus.clk_out), 0);
        check("arst_busy", int'(bus.busy), 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("arst_ready", int'(bus.cfg_ready), 1);
        check("arst_no_done", done_cnt - d0, 0);

`ifdef CLK_GEN_PAUSE_EN
        // A 5-cycle pause stretches one period from 8 to 13.
        send('{MODE_RUN, 8'd3, 8'd0});
        r0 = rise_cnt;
        wait_rises(r0 + 1, "pause_first_rise_timeout");
        bus.pause = 1'b1;
        step(5);
        bus.pause = 1'b0;
        wait_rises(r0 + 2, "pause_second_rise_timeout");
        check("pause_gap", rise_gap, 13);
        send('{MODE_STOP, 8'd0, 8'd0});
        wait_idle("pause_stop_timeout");
`endif

        // Randomized traffic; source holds its offer while a config is pending.
        for (int i = 0; i < 3000; i++) begin
            if (bus.cfg_ready) begin
                bus.cfg_valid = ($urandom_range(0, 5) == 0);
                bus.cfg_mode  = 2'($urandom_range(0, 3));
                bus.cfg_div   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20))
                                                             : 8'($urandom_range(0, 3));
                bus.cfg_burst = 8'($urandom_range(0, 4));
            end
`ifdef CLK_GEN_PAUSE_EN
            bus.pause = ($urandom_range(0, 7) == 0);
`endif
            step();
        end
        bus.cfg_valid = 1'b0;
`ifdef CLK_GEN_PAUSE_EN
        bus.pause = 1'b0;
`endif
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
